// File: rtl/rf_wb_arbiter.sv
// Two-requester write-back arbiter for the register file's single write port.
// Each requester has a one-entry buffer; full buffers are granted oldest-first onto registered RF outputs.
module rf_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_r0_valid,
  input  logic [AW-1:0]     i_r0_wa,
  input  logic [DW-1:0]     i_r0_wd,
  output logic              o_r0_ready,
  input  logic              i_r1_valid,
  input  logic [AW-1:0]     i_r1_wa,
  input  logic [DW-1:0]     i_r1_wd,
  output logic              o_r1_ready,
  output logic              o_rf_en,
  output logic [AW-1:0]     o_rf_wa,
  output logic [DW-1:0]     o_rf_wd,
  output logic [2**AW-1:0]  o_pend_mask,
  output logic              o_idle
);

  logic [1:0]          r_full;
  logic [1:0][AW-1:0]  r_wa;
  logic [1:0][DW-1:0]  r_wd;
  logic                r_old;  // 0: buffer 0 is older, 1: buffer 1 is older

  logic [1:0]          w_valid, w_gnt, w_rdy, w_cap, w_kept;
  logic [1:0][AW-1:0]  w_in_wa;
  logic [1:0][DW-1:0]  w_in_wd;
  logic                w_old_nxt, w_sel;

  assign w_valid = {i_r1_valid, i_r0_valid};
  assign w_in_wa = {i_r1_wa, i_r0_wa};
  assign w_in_wd = {i_r1_wd, i_r0_wd};

  always_comb begin
    w_gnt[0] = r_full[0] && (!r_full[1] || !r_old);
    w_gnt[1] = r_full[1] && (!r_full[0] ||  r_old);
    w_rdy    = ~r_full | w_gnt;
    for (int k = 0; k < 2; k++)
      w_cap[k] = w_valid[k] && w_rdy[k] && (w_in_wa[k] != '0);
    w_kept   = r_full & ~w_gnt;
    w_sel    = w_gnt[1];
    // An entry that stays buffered is always older than anything captured this edge.
    w_old_nxt = r_old;
    if (w_kept[0])      w_old_nxt = 1'b0;
    else if (w_kept[1]) w_old_nxt = 1'b1;
    else if (w_cap[0])  w_old_nxt = 1'b0;
    else if (w_cap[1])  w_old_nxt = 1'b1;
  end

  assign o_r0_ready = w_rdy[0];
  assign o_r1_ready = w_rdy[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full <= '0;
      r_wa   <= '0;
      r_wd   <= '0;
      r_old  <= 1'b0;
    end else begin
      r_old <= w_old_nxt;
      for (int k = 0; k < 2; k++) begin
        if (w_cap[k]) begin
          r_full[k] <= 1'b1;
          r_wa[k]   <= w_in_wa[k];
          r_wd[k]   <= w_in_wd[k];
        end else if (w_gnt[k]) begin
          r_full[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rf_en <= 1'b0;
      o_rf_wa <= '0;
      o_rf_wd <= '0;
    end else if (|w_gnt) begin
      o_rf_en <= 1'b1;
      o_rf_wa <= r_wa[w_sel];
      o_rf_wd <= r_wd[w_sel];
    end else begin
      o_rf_en <= 1'b0;
    end
  end

  // x0 is never buffered, but RF_WA resets to 0, so bit 0 is tied off explicitly.
  assign o_pend_mask[0] = 1'b0;
  for (genvar i = 1; i < 2**AW; i++) begin : g_pend
    assign o_pend_mask[i] = (r_full[0] && r_wa[0] == AW'(i)) ||
                            (r_full[1] && r_wa[1] == AW'(i)) ||
                            (o_rf_en   && o_rf_wa == AW'(i));
  end

  assign o_idle = !r_full[0] && !r_full[1] && !o_rf_en;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed sequences push expected RF writes,
// a negedge monitor pops and compares every RF_EN cycle.
module tb_rf_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          v0 = 1'b0, v1 = 1'b0;
  logic [AW-1:0] wa0 = '0, wa1 = '0;
  logic [DW-1:0] wd0 = '0, wd1 = '0;
  logic          rdy0, rdy1, rf_en, idle;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic [31:0]   pend;

  rf_wb_arbiter #(.DW(DW), .AW(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_r0_valid(v0), .i_r0_wa(wa0), .i_r0_wd(wd0), .o_r0_ready(rdy0),
    .i_r1_valid(v1), .i_r1_wa(wa1), .i_r1_wd(wd1), .o_r1_ready(rdy1),
    .o_rf_en(rf_en), .o_rf_wa(rf_wa), .o_rf_wd(rf_wd),
    .o_pend_mask(pend), .o_idle(idle)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, en_count = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] q0[$], q1[$];
  logic [DW-1:0] dut_rf [32];
  logic [DW-1:0] ref_rf [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
    ref_rf[a] = d;
  endtask

  // Monitor: every RF_EN cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && rf_en) begin
      en_count++;
      dut_rf[rf_wa] = rf_wd;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got wa=%0d wd=%0h expected none", rf_wa, rf_wd);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        chk("rf_write", {27'd0, rf_wa, rf_wd}, {27'd0, e});
      end
    end
  end

  task automatic drive(input int max_cyc);
    int cyc = 0;
    logic f0, f1;
    while ((q0.size() > 0 || q1.size() > 0) && cyc < max_cyc) begin
      @(negedge clk);
      v0 = (q0.size() > 0);
      v1 = (q1.size() > 0);
      if (v0) {wa0, wd0} = q0[0];
      if (v1) {wa1, wd1} = q1[0];
      #1;
      f0 = v0 && rdy0;
      f1 = v1 && rdy1;
      @(posedge clk);
      if (f0) void'(q0.pop_front());
      if (f1) void'(q1.pop_front());
      cyc++;
    end
    if (q0.size() > 0 || q1.size() > 0) chk("drive_timeout", 64'(q0.size() + q1.size()), 64'd0);
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    @(negedge clk);
    while (!(idle && exp_q.size() == 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {63'd0, idle}, 64'd1);
  endtask

  initial begin
    int base;
    logic [DW-1:0] s11, s12;
    for (int i = 0; i < 32; i++) begin dut_rf[i] = '0; ref_rf[i] = '0; end

    // Reset held with R0 already presenting x5
    v0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    chk("rst_rf_en", {63'd0, rf_en}, 64'd0);
    chk("rst_pend", {32'd0, pend}, 64'd0);
    chk("rst_idle", {63'd0, idle}, 64'd1);
    chk("rst_ready", {62'd0, rdy1, rdy0}, 64'd3);
    chk("rst_rf_wa", {59'd0, rf_wa}, 64'd0);
    push_exp(5'd5, 32'hDEADBEEF);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk); v0 = 1'b0;
    chk("lat_e0_pend", {32'd0, pend}, 64'h20);
    chk("lat_e0_en", {63'd0, rf_en}, 64'd0);
    @(negedge clk);
    chk("lat_e1_en", {63'd0, rf_en}, 64'd1);
    chk("lat_e1_pend", {32'd0, pend}, 64'h20);
    @(negedge clk);
    chk("lat_e2_pend", {32'd0, pend}, 64'd0);
    chk("lat_e2_idle", {63'd0, idle}, 64'd1);

    // Simultaneous: x3 then x4, R1 stalled one cycle
    push_exp(5'd3, 32'h11);
    push_exp(5'd4, 32'h22);
    v0 = 1'b1; wa0 = 5'd3; wd0 = 32'h11;
    v1 = 1'b1; wa1 = 5'd4; wd1 = 32'h22;
    #1 chk("sim_ready_pre", {62'd0, rdy1, rdy0}, 64'd3);
    @(posedge clk);
    @(negedge clk); v0 = 1'b0; v1 = 1'b0;
    chk("sim_ready_stall", {62'd0, rdy1, rdy0}, 64'd1);
    @(negedge clk);
    chk("sim_ready1_back", {63'd0, rdy1}, 64'd1);
    wait_idle(20);

    // Same register: R1 x7=AA contended behind R0, then R0 x7=BB
    push_exp(5'd2, 32'h5);
    push_exp(5'd7, 32'hAA);
    push_exp(5'd7, 32'hBB);
    q0.push_back({5'd2, 32'h5});
    q0.push_back({5'd7, 32'hBB});
    q1.push_back({5'd7, 32'hAA});
    drive(20);
    wait_idle(20);
    chk("same_reg_x7", {32'd0, dut_rf[7]}, 64'hBB);

    // x0 discard
    @(negedge clk);
    v0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF;
    #1 chk("x0_ready", {63'd0, rdy0}, 64'd1);
    @(posedge clk);
    @(negedge clk); v0 = 1'b0;
    chk("x0_idle", {63'd0, idle}, 64'd1);
    chk("x0_pend", {32'd0, pend}, 64'd0);
    @(negedge clk);
    chk("x0_rf_en", {63'd0, rf_en}, 64'd0);

    // Saturation: 10 requests each, both streaming; grants must alternate R0,R1
    base = en_count;
    for (int i = 0; i < 10; i++) begin
      logic [AW-1:0] a0, a1;
      a0 = AW'($urandom_range(1, 31));
      a1 = AW'($urandom_range(1, 31));
      q0.push_back({a0, 32'hA000_0000 | i});
      q1.push_back({a1, 32'hB000_0000 | i});
      push_exp(a0, 32'hA000_0000 | i);
      push_exp(a1, 32'hB000_0000 | i);
    end
    drive(60);
    wait_idle(20);
    chk("sat_en_count", 64'(en_count - base), 64'd20);
    for (int i = 0; i < 32; i++) chk($sformatf("rf_x%0d", i), {32'd0, dut_rf[i]}, {32'd0, ref_rf[i]});

    // Reset mid-operation: both buffers full, one write on RF_*
    s11 = dut_rf[11]; s12 = dut_rf[12];
    @(negedge clk);
    v0 = 1'b1; wa0 = 5'd11; wd0 = 32'h111;
    v1 = 1'b1; wa1 = 5'd12; wd1 = 32'h222;
    @(posedge clk);
    @(negedge clk); v0 = 1'b0; v1 = 1'b0;
    chk("mid_pend_full", {32'd0, pend}, 64'h1800);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_en", {63'd0, rf_en}, 64'd0);
    chk("mid_rst_pend", {32'd0, pend}, 64'd0);
    chk("mid_rst_idle", {63'd0, idle}, 64'd1);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_post_idle", {63'd0, idle}, 64'd1);
    chk("mid_x11", {32'd0, dut_rf[11]}, {32'd0, s11});
    chk("mid_x12", {32'd0, dut_rf[12]}, {32'd0, s12});
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter for the 32 x 32 register file's single write port. It accepts register write requests from two producers: requester 0 (ALU/immediate write-back) and requester 1 (load unit). Each requester has its own one-entry buffer. Buffered writes are granted oldest-first and driven onto the register file's RF_WA/RF_WD/RF_EN inputs through registered outputs. A pending-write mask tells issue logic which registers still have writes in flight.

## Interface
- DW, 32, write data width
- AW, 5, register address width; PEND_MASK is 2**AW bits
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- R0_VALID  in  1  requester 0 has a write
- R0_WA  in  AW  requester 0 destination register
- R0_WD  in  DW  requester 0 write data
- R0_READY  out  1  requester 0 handshake; transfer when R0_VALID && R0_READY at a rising edge
- R1_VALID, R1_WA, R1_WD, R1_READY  same as requester 0, for requester 1
- RF_EN  out  1  register file write enable (registered)
- RF_WA  out  AW  register file write address (registered)
- RF_WD  out  DW  register file write data (registered)
- PEND_MASK  out  2**AW  bit i = 1 while a write to register i is buffered or on RF_*
- IDLE  out  1  both buffers empty and RF_EN = 0

## Operation
- Per-requester buffer state: FULLx, WAx, WDx. There is also one age bit, OLD, which names the older full buffer.
- Accept: on a rising edge with Rx_VALID && Rx_READY && RST_N high:
  - WAx != 0: FULLx <= 1, capture WA/WD.
  - WAx == 0: request is consumed and discarded. FULLx is unchanged, it never reaches RF_*, and PEND_MASK is unaffected.
- Grant (combinational):
  - Exactly one buffer full: grant it.
  - Both full: grant the buffer indicated by OLD.
  - OLD rule: the buffer captured at the earlier edge is older. If both were captured on the same edge, R0 is older.
- Drain: at the edge where buffer x is granted:
  - RF_EN <= 1, RF_WA <= WAx, RF_WD <= WDx.
  - FULLx clears unless a new request is captured into x on the same edge.
- No grant: RF_EN <= 0. RF_WA and RF_WD hold their values.
- Rx_READY = !FULLx || grantx. It never depends on Rx_VALID, so there is no combinational loop.
  - A full, non-granted buffer stalls its requester.
- Starvation: a non-granted full buffer becomes the older one after the other buffer drains, so it is granted next cycle at the latest. Maximum wait is 1 cycle behind the other requester.
- Same-address ordering: if both buffers target the same register, the older write reaches RF_* first. The register ends holding the younger data.
- PEND_MASK[i] = (FULL0 && WA0==i) || (FULL1 && WA1==i) || (RF_EN && RF_WA==i). PEND_MASK[0] is always 0.

## Timing
- Reset (RST_N low, takes effect immediately):
  - FULL0 = FULL1 = 0, OLD = R0.
  - RF_EN = 0, RF_WA = 0, RF_WD = 0.
  - PEND_MASK = 0, IDLE = 1.
  - R0_READY = R1_READY = 1, but no capture occurs while RST_N is low.
- Latency (no contention), for a request accepted at edge E:
  - RF_EN = 1 during the cycle from E+1 to E+2.
  - The register file writes at edge E+2.
  - The PEND bit is set from E and cleared after E+2.
- Throughput: one register-file write per cycle in aggregate. A single requester streaming alone gets 1 write/cycle with READY held high.
- Contention, both requesters valid every cycle: grants alternate R0, R1, R0 and so on. Each requester sees READY high every other cycle.
- Reset mid-operation: buffered and in-flight writes are dropped and RF_EN falls asynchronously. The requester must re-issue.

## Test plan
- Reset with R0 writing x5 = 0xDEADBEEF, then release reset. RF_EN = 0 and PEND_MASK = 0 during reset. After release, R0 writes x5 = 0xDEADBEEF at edge E. Required:
  - RF_EN = 1, RF_WA = 5, RF_WD = 0xDEADBEEF in cycle E+1.
  - PEND_MASK[5] = 1 from E until edge E+2.
- Simultaneous requests: R0 writes x3 = 0x11 and R1 writes x4 = 0x22 on the same edge. Required:
  - x3 is driven first, x4 the next cycle.
  - R1_READY = 0 for one cycle.
- Same register: R1 writes x7 = 0xAA one edge before R0 writes x7 = 0xBB, with R1 contended. Required: RF_* sequence is 0xAA then 0xBB, and the register file ends with x7 = 0xBB.
- x0 discard: R0 writes x0 = 0xFFFFFFFF. Required: READY = 1, RF_EN never asserts, PEND_MASK = 0, IDLE stays 1.
- Saturation: both requesters valid for 20 cycles with random addresses 1-31. Required:
  - Exactly 20 RF_EN cycles, strictly alternating grants.
  - No request lost or duplicated.
  - Register-file contents match a reference model.
- Reset mid-operation: both buffers full, then RST_N pulses low. Required:
  - RF_EN = 0 immediately, PEND_MASK = 0, IDLE = 1.
  - No register-file write for the dropped requests.
